fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register, one-entry hold buffer and redirect handling
//   clk, rst (async, active-high)
//   PCWrite, IF_ID_Write : stall controls from hazard detection (advance = both high)
//   flush, branchTarget  : redirect fetch to a new word-aligned address
//   imem_req/imem_addr   : request to instruction memory, held until imem_ack
//   imem_ack/imem_rdata  : request completion and fetched instruction
//   IF_ID_pc/instr/valid : registered IF/ID contents (valid=0 marks a bubble)
//   fetchStall           : no instruction can be supplied this cycle
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        flush,
    input  logic [31:0] branchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
    output logic        fetchStall
);
    typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] drop_addr;
    logic        advance;
    assign advance    = PCWrite & IF_ID_Write;
    // In DROP the pre-redirect request is still in flight, so its address stays on the bus
    assign imem_addr  = state == DROP ? drop_addr : pc;
    assign imem_req   = ~rst & (state != HOLD);
    assign fetchStall = (state == DROP) | ((state == REQ) & ~imem_ack);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            hold_pc     <= '0;
            hold_instr  <= '0;
            drop_addr   <= '0;
            IF_ID_pc    <= '0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (flush) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            pc          <= branchTarget & 32'hFFFF_FFFC;
            hold_pc     <= '0;
            hold_instr  <= '0;
            if (state == HOLD || imem_ack) begin
                state <= REQ;
            end else begin
                // Only capture the in-flight address when first entering DROP
                if (state == REQ) drop_addr <= pc;
                state <= DROP;
            end
        end else begin
            case (state)
                REQ: begin
                    if (imem_ack && advance) begin
                        IF_ID_pc    <= pc;
                        IF_ID_instr <= imem_rdata;
                        IF_ID_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                    end else if (imem_ack) begin
                        hold_pc    <= pc;
                        hold_instr <= imem_rdata;
                        state      <= HOLD;
                    end else if (IF_ID_Write) begin
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        IF_ID_pc    <= hold_pc;
                        IF_ID_instr <= hold_instr;
                        IF_ID_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                        state       <= REQ;
                    end
                end
                default: begin
                    // Response to the abandoned request is discarded
                    if (imem_ack) state <= REQ;
                    if (IF_ID_Write) begin
                        IF_ID_instr <= NOP_INSTR;
                        IF_ID_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard-driven bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b0;
    logic        IF_ID_Write = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branchTarget = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        fetchStall;
    int          tests = 0;
    int          failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    fetch_unit dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .flush(flush), .branchTarget(branchTarget), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
        .fetchStall(fetchStall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic pw, input logic iw, input logic ak);
        PCWrite = pw;
        IF_ID_Write = iw;
        imem_ack = ak;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if (IF_ID_valid !== 1'b0 || IF_ID_pc !== 32'd0 || IF_ID_instr !== NOP || imem_req !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: valid=%b pc=%h instr=%h req=%b, want 0/0/%h/0", IF_ID_valid, IF_ID_pc, IF_ID_instr, imem_req, NOP);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || fetchStall !== 1'b1) begin
            failed++;
            $display("FAIL reset_release: req=%b addr=%h stall=%b, want 1/0/1", imem_req, imem_addr, fetchStall);
        end
    endtask

    task automatic test_stream();
        do_reset();
        set_in(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i * 4));
            tick();
            e = exp_q.pop_front();
            tests++;
            if (IF_ID_pc !== e || IF_ID_instr !== mem(e) || IF_ID_valid !== 1'b1) begin
                failed++;
                $display("FAIL stream: pc=%h instr=%h valid=%b, want %h/%h/1", IF_ID_pc, IF_ID_instr, IF_ID_valid, e, mem(e));
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        tick();
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        tests++;
        if (IF_ID_pc !== 32'd4 || imem_req !== 1'b0 || fetchStall !== 1'b0) begin
            failed++;
            $display("FAIL load_use_hold: pc=%h req=%b stall=%b, want 4/0/0", IF_ID_pc, imem_req, fetchStall);
        end
        set_in(1'b1, 1'b1, 1'b1);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd12);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            tests++;
            if (IF_ID_pc !== e || IF_ID_instr !== mem(e) || IF_ID_valid !== 1'b1) begin
                failed++;
                $display("FAIL load_use_resume: pc=%h instr=%h valid=%b, want %h/%h/1", IF_ID_pc, IF_ID_instr, IF_ID_valid, e, mem(e));
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        set_in(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (fetchStall !== 1'b1 || IF_ID_valid !== 1'b0 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                failed++;
                $display("FAIL wait_bubble: stall=%b valid=%b addr=%h req=%b, want 1/0/10/1", fetchStall, IF_ID_valid, imem_addr, imem_req);
            end
        end
        imem_ack = 1'b1;
        exp_q.push_back(32'h10);
        tick();
        e = exp_q.pop_front();
        tests++;
        if (IF_ID_pc !== e || IF_ID_instr !== mem(e) || IF_ID_valid !== 1'b1) begin
            failed++;
            $display("FAIL wait_done: pc=%h instr=%h valid=%b, want %h/%h/1", IF_ID_pc, IF_ID_instr, IF_ID_valid, e, mem(e));
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_in(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        imem_ack = 1'b0;
        tick();
        flush = 1'b1;
        branchTarget = 32'h103;
        tick();
        flush = 1'b0;
        tests++;
        if (imem_addr !== 32'h20 || fetchStall !== 1'b1 || IF_ID_valid !== 1'b0 || imem_req !== 1'b1) begin
            failed++;
            $display("FAIL flush_drop: addr=%h stall=%b valid=%b req=%b, want 20/1/0/1", imem_addr, fetchStall, IF_ID_valid, imem_req);
        end
        imem_ack = 1'b1;
        tick();
        tests++;
        if (imem_addr !== 32'h100 || IF_ID_valid !== 1'b0) begin
            failed++;
            $display("FAIL flush_discard: addr=%h valid=%b, want 100/0", imem_addr, IF_ID_valid);
        end
        exp_q.push_back(32'h100);
        tick();
        e = exp_q.pop_front();
        tests++;
        if (IF_ID_pc !== e || IF_ID_instr !== mem(e) || IF_ID_valid !== 1'b1) begin
            failed++;
            $display("FAIL flush_target: pc=%h instr=%h valid=%b, want %h/%h/1", IF_ID_pc, IF_ID_instr, IF_ID_valid, e, mem(e));
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1;
        branchTarget = 32'hFFFF_FFFE;
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        flush = 1'b0;
        tests++;
        if (imem_addr !== 32'hFFFF_FFFC || IF_ID_valid !== 1'b0) begin
            failed++;
            $display("FAIL wrap_redirect: addr=%h valid=%b, want fffffffc/0", imem_addr, IF_ID_valid);
        end
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            tests++;
            if (IF_ID_pc !== e || IF_ID_instr !== mem(e) || IF_ID_valid !== 1'b1 || imem_addr !== e + 32'd4) begin
                failed++;
                $display("FAIL wrap: pc=%h instr=%h valid=%b addr=%h, want %h/%h/1/%h", IF_ID_pc, IF_ID_instr, IF_ID_valid, imem_addr, e, mem(e), e + 32'd4);
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        tests++;
        if (imem_req !== 1'b0 || IF_ID_valid !== 1'b1) begin
            failed++;
            $display("FAIL hold_enter: req=%b valid=%b, want 0/1", imem_req, IF_ID_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (IF_ID_valid !== 1'b0 || IF_ID_pc !== 32'd0 || IF_ID_instr !== NOP || imem_req !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: valid=%b pc=%h instr=%h req=%b, want 0/0/%h/0", IF_ID_valid, IF_ID_pc, IF_ID_instr, imem_req, NOP);
        end
        set_in(1'b1, 1'b1, 1'b1);
        tick();
        tests++;
        if (IF_ID_valid !== 1'b0 || imem_addr !== 32'd0) begin
            failed++;
            $display("FAIL late_ack_in_reset: valid=%b addr=%h, want 0/0", IF_ID_valid, imem_addr);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            failed++;
            $display("FAIL async_release: req=%b addr=%h, want 1/0", imem_req, imem_addr);
        end
        exp_q.push_back(32'd0);
        tick();
        e = exp_q.pop_front();
        tests++;
        if (IF_ID_pc !== e || IF_ID_instr !== mem(e) || IF_ID_valid !== 1'b1) begin
            failed++;
            $display("FAIL async_first_fetch: pc=%h instr=%h valid=%b, want %h/%h/1", IF_ID_pc, IF_ID_instr, IF_ID_valid, e, mem(e));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_wait_states();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
